// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution channel scheduler: FSM state
// encoding, settle counter width, performance counter width and the
// channel-count width helper.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FIN    = 3'd4
    } sched_state_t;

    // Width of the settle down-counter (CONV_LAT is at most 255).
    localparam int SETTLE_W = 8;

    // Width of the optional busy-cycle performance counter.
    localparam int PERF_W = 32;

    // Bits needed to hold any channel count 0..outch inclusive.
    function automatic int ch_width(input int outch);
        return $clog2(outch + 1);
    endfunction

endpackage

// File: rtl/conv_settle_timer.sv
// Settle down-counter for the Conv2d result. Loaded with CONV_LAT-1 when a
// channel's parameters are latched, counts down while the scheduler waits,
// and flags zero on the last settle cycle.
module conv_settle_timer
    import conv_sched_pkg::*;
(
    input  logic                clk,
    input  logic                global_rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] value,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] count;

    // Reload on a parameter latch, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            count <= {SETTLE_W{1'b0}};
        end else if (load) begin
            count <= value;
        end else if (dec && (count != {SETTLE_W{1'b0}})) begin
            count <= count - SETTLE_W'(1);
        end
    end

    assign zero = (count == {SETTLE_W{1'b0}});

endmodule

// File: rtl/conv_channel_sched.sv
// Per-layer output-channel scheduler for a Conv2d engine: fetches weights
// and bias for each channel, waits for the convolution result to settle,
// then hands the result to the writer with a valid/ready handshake.
// Optional feature: define CONV_CHANNEL_SCHED_PERF_EN to add the 32-bit
// perf_cycles busy-cycle counter output.
module conv_channel_sched
    import conv_sched_pkg::*;
#(
    parameter  int N        = 24,
    parameter  int OUTCH    = 256,
    parameter  int CONV_LAT = 4,
    localparam int CH_W     = ch_width(OUTCH)
) (
    input  logic              clk,
    input  logic              global_rst,
    input  logic              start,
    input  logic [CH_W-1:0]   num_ch,
    output logic              busy,
    output logic              done,
    output logic              par_req,
    output logic [CH_W-1:0]   par_addr,
    input  logic              par_ack,
    output logic              conv_load,
    output logic              res_valid,
    input  logic              res_ready,
`ifdef CONV_CHANNEL_SCHED_PERF_EN
    output logic [PERF_W-1:0] perf_cycles,
`endif
    output logic [CH_W-1:0]   res_ch
);

    // Reject parameter values the datapath cannot represent.
    generate
        if ((N < 1) || (CONV_LAT < 1) || (CONV_LAT > 255)) begin : g_bad_param
            $error("conv_channel_sched: N must be >= 1 and CONV_LAT within 1..255");
        end
    endgenerate

    sched_state_t    state;
    sched_state_t    state_next;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] num_lat;
    logic [CH_W-1:0] num_sat;
    logic [CH_W-1:0] ch_inc;
    logic            accept;
    logic            xfer;
    logic            last;
    logic            settle_load;
    logic            settle_zero;

    // Requests for more channels than the engine supports are clamped.
    assign num_sat     = (num_ch > CH_W'(OUTCH)) ? CH_W'(OUTCH) : num_ch;
    assign accept      = (state == ST_IDLE) && start;
    assign xfer        = (state == ST_EMIT) && res_ready;
    assign ch_inc      = ch + CH_W'(1);
    assign last        = !(ch_inc < num_lat);
    assign settle_load = (state == ST_FETCH) && par_ack;

    conv_settle_timer u_settle (
        .clk        (clk),
        .global_rst (global_rst),
        .load       (settle_load),
        .value      (SETTLE_W'(CONV_LAT - 1)),
        .dec        (state == ST_SETTLE),
        .zero       (settle_zero)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; start, par_ack and res_ready only matter in their own state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_ch == {CH_W{1'b0}}) ? ST_FIN : ST_FETCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (par_ack) begin
                    state_next = ST_SETTLE;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    state_next = ST_EMIT;
                end else begin
                    state_next = ST_SETTLE;
                end
            end
            ST_EMIT: begin
                if (res_ready) begin
                    state_next = last ? ST_FIN : ST_FETCH;
                end else begin
                    state_next = ST_EMIT;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; conv_load is the only one that also depends on an input (par_ack).
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        par_req   = 1'b0;
        par_addr  = {CH_W{1'b0}};
        conv_load = 1'b0;
        res_valid = 1'b0;
        res_ch    = {CH_W{1'b0}};
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_FETCH: begin
                busy      = 1'b1;
                par_req   = 1'b1;
                par_addr  = ch;
                conv_load = par_ack;
            end
            ST_SETTLE: begin
                busy = 1'b1;
            end
            ST_EMIT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_ch    = ch;
            end
            ST_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Channel index and latched channel count; the count is frozen for the whole layer.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            ch      <= {CH_W{1'b0}};
            num_lat <= {CH_W{1'b0}};
        end else if (accept) begin
            ch      <= {CH_W{1'b0}};
            num_lat <= num_sat;
        end else if (xfer && !last) begin
            ch <= ch_inc;
        end
    end

`ifdef CONV_CHANNEL_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_count;

    // Busy-cycle counter: the start-accept cycle counts as 1, then every busy cycle, saturating.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            perf_count <= {PERF_W{1'b0}};
        end else if (accept) begin
            perf_count <= PERF_W'(1);
        end else if ((state != ST_IDLE) && (perf_count != {PERF_W{1'b1}})) begin
            perf_count <= perf_count + PERF_W'(1);
        end
    end

    assign perf_cycles = perf_count;
`endif

endmodule

// File: tb/tb_conv_channel_sched.sv
// Scoreboard bench for conv_channel_sched: stimulus pushes expected events
// (conv_load per channel, result transfer per channel, done) and a monitor
// pops and compares them as the DUT produces them. Timing and stability
// properties are checked directly by the directed tests.
module tb_conv_channel_sched;

    localparam int N        = 24;
    localparam int OUTCH    = 256;
    localparam int CONV_LAT = 4;
    localparam int CH_W     = $clog2(OUTCH + 1);

    logic            clk = 1'b0;
    logic            global_rst;
    logic            start;
    logic [CH_W-1:0] num_ch;
    logic            busy;
    logic            done;
    logic            par_req;
    logic [CH_W-1:0] par_addr;
    logic            par_ack;
    logic            conv_load;
    logic            res_valid;
    logic            res_ready;
    logic [CH_W-1:0] res_ch;
`ifdef CONV_CHANNEL_SCHED_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    conv_channel_sched #(.N(N), .OUTCH(OUTCH), .CONV_LAT(CONV_LAT)) dut (
        .clk         (clk),
        .global_rst  (global_rst),
        .start       (start),
        .num_ch      (num_ch),
        .busy        (busy),
        .done        (done),
        .par_req     (par_req),
        .par_addr    (par_addr),
        .par_ack     (par_ack),
        .conv_load   (conv_load),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
`ifdef CONV_CHANNEL_SCHED_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .res_ch      (res_ch)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_LOAD = 0, EV_XFER = 1, EV_DONE = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       idx;
    } ev_t;

    ev_t exp_q[$];
    int  load_cycles[$];
    int  cyc          = 0;
    int  n_checks     = 0;
    int  n_fail       = 0;
    int  xfer_cyc     = 0;
    int  done_cyc     = 0;
    int  done_seen    = 0;
    int  busy_seen    = 0;
    int  par_req_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int idx);
        ev_t e;
        e.kind = k;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic push_layer(input int n);
        for (int c = 0; c < n; c++) begin
            push_ev(EV_LOAD, c);
            push_ev(EV_XFER, c);
        end
        push_ev(EV_DONE, 0);
    endtask

    task automatic pop_check(input ev_kind_t k, input int idx, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected event idx %0d, scoreboard empty (cycle %0d)", name, idx, cyc);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, k, e.kind);
            check({name, "_idx"}, idx, e.idx);
        end
    endtask

    // Monitor: sample away from the active edge and score every DUT event.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_seen++;
        if (par_req === 1'b1) par_req_seen++;
        if (conv_load === 1'b1) begin
            load_cycles.push_back(cyc);
            pop_check(EV_LOAD, int'(par_addr), "conv_load");
            check("load_while_valid", res_valid, 0);
        end
        if ((res_valid === 1'b1) && (res_ready === 1'b1)) begin
            xfer_cyc = cyc;
            pop_check(EV_XFER, int'(res_ch), "res_xfer");
        end
        if (done === 1'b1) begin
            done_cyc = cyc;
            done_seen++;
            pop_check(EV_DONE, 0, "done");
        end
    end

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return res_valid;
            1:       return par_req;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; (i < budget) && !seen; i++) begin
            @(negedge clk);
            seen = sig_sel(sel);
        end
        check({name, "_seen"}, seen, 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((exp_q.size() == 0) && (busy === 1'b0)) break;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_par_req"}, par_req, 0);
        check({name, "_par_addr"}, par_addr, 0);
        check({name, "_conv_load"}, conv_load, 0);
        check({name, "_res_valid"}, res_valid, 0);
        check({name, "_res_ch"}, res_ch, 0);
    endtask

    // One-cycle start pulse; num_ch is then scrambled to prove it was latched.
    task automatic start_layer(input int n);
        @(posedge clk);
        #1;
        start  = 1'b1;
        num_ch = CH_W'(n);
        @(posedge clk);
        #1;
        start  = 1'b0;
        num_ch = CH_W'(7);
    endtask

    task automatic stall_emit(input int exp_ch, input string name);
        int loads0;
        wait_sig(0, 20, name);
        loads0 = load_cycles.size();
        repeat (10) begin
            @(negedge clk);
            check({name, "_valid"}, res_valid, 1);
            check({name, "_ch"}, res_ch, exp_ch);
            check({name, "_par_req"}, par_req, 0);
        end
        check({name, "_no_load"}, load_cycles.size(), loads0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic delay_ack(input int exp_addr, input string name);
        int loads0;
        wait_sig(1, 20, name);
        loads0 = load_cycles.size();
        repeat (5) begin
            @(negedge clk);
            check({name, "_req"}, par_req, 1);
            check({name, "_addr"}, par_addr, exp_addr);
        end
        check({name, "_no_early_load"}, load_cycles.size(), loads0);
        @(posedge clk);
        #1 par_ack = 1'b1;
        @(negedge clk);
        check({name, "_load_on_ack"}, conv_load, 1);
        @(posedge clk);
        #1 par_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bs0;
        int pr0;
        int ds0;
        int reached;

        global_rst = 1'b1;
        start      = 1'b0;
        num_ch     = '0;
        par_ack    = 1'b0;
        res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 global_rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
`ifdef CONV_CHANNEL_SCHED_PERF_EN
        check("reset_perf", perf_cycles, 0);
`endif

        // Zero-stall layer of 3 channels, with a start attempt mid-layer.
        par_ack   = 1'b1;
        res_ready = 1'b1;
        load_cycles.delete();
        push_layer(3);
        start_layer(3);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        num_ch = CH_W'(5);
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain(100, "t1");
        check("t1_loads", load_cycles.size(), 3);
        if (load_cycles.size() >= 3) begin
            check("t1_gap01", load_cycles[1] - load_cycles[0], 6);
            check("t1_gap12", load_cycles[2] - load_cycles[1], 6);
        end
        check("t1_done_lat", done_cyc - xfer_cyc, 1);

        // Writer back-pressure: 10+ stall cycles in EMIT for each of 2 channels.
        par_ack   = 1'b1;
        res_ready = 1'b0;
        push_layer(2);
        start_layer(2);
        stall_emit(0, "t2_ch0");
        stall_emit(1, "t2_ch1");
        wait_drain(50, "t2");

        // Parameter memory answers 5 cycles late for each of 2 channels.
        par_ack   = 1'b0;
        res_ready = 1'b1;
        push_layer(2);
        start_layer(2);
        delay_ack(0, "t3_ch0");
        delay_ack(1, "t3_ch1");
        wait_drain(50, "t3");

        // Empty layer: start held into FIN must not restart it.
        par_ack   = 1'b1;
        res_ready = 1'b1;
        push_ev(EV_DONE, 0);
        bs0 = busy_seen;
        pr0 = par_req_seen;
        @(posedge clk);
        #1 start = 1'b1;
        num_ch = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain(20, "t4");
        repeat (3) @(negedge clk);
        check("t4_busy_cycles", busy_seen - bs0, 1);
        check("t4_no_par_req", par_req_seen - pr0, 0);

        // Reset during SETTLE of channel 1, then a fresh 2-channel layer.
        load_cycles.delete();
        push_layer(3);
        start_layer(3);
        reached = 0;
        for (int i = 0; (i < 40) && (reached == 0); i++) begin
            @(negedge clk);
            if (load_cycles.size() == 2) reached = 1;
        end
        check("t5_reached_ch1", reached, 1);
        @(posedge clk);
        #1 global_rst = 1'b1;
        check("t5_progress", exp_q.size(), 4);
        exp_q.delete();
        ds0 = done_seen;
        @(posedge clk);
        #1 global_rst = 1'b0;
        @(negedge clk);
        check_all_zero("t5_rst");
`ifdef CONV_CHANNEL_SCHED_PERF_EN
        check("t5_rst_perf", perf_cycles, 0);
`endif
        repeat (5) @(negedge clk);
        check("t5_no_done", done_seen - ds0, 0);
        push_layer(2);
        start_layer(2);
        wait_drain(50, "t5_rerun");

`ifdef CONV_CHANNEL_SCHED_PERF_EN
        // Busy-cycle count for a zero-stall 2-channel layer, held after done.
        push_layer(2);
        start_layer(2);
        wait_drain(50, "t6");
        check("t6_perf", perf_cycles, 14);
        repeat (3) @(negedge clk);
        check("t6_perf_held", perf_cycles, 14);
`endif

        // Oversized request saturates to OUTCH channels (last index OUTCH-1).
        load_cycles.delete();
        push_layer(OUTCH);
        start_layer(300);
        wait_drain(OUTCH * 6 + 50, "t7");
        check("t7_loads", load_cycles.size(), OUTCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_channel_sched.md
CONV_CHANNEL_SCHED -- requirements
Module: conv_channel_sched

Interface
REQ-001 SHALL have parameter N, default 24: fixed-point word width of the bias word passed through (Q13 format upstream).
REQ-002 SHALL have parameter OUTCH, default 256: maximum number of output channels per layer.
REQ-003 SHALL have parameter CONV_LAT, default 4: clk cycles from conv_load until the Conv2d result is stable; legal range 1..255.
REQ-004 SHALL have localparam CH_W = $clog2(OUTCH+1), the width of channel counts and indices.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port global_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1: request to run a layer; sampled only in IDLE.
REQ-008 SHALL have port num_ch, input, CH_W: output channels to process; sampled with start.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when the layer completes.
REQ-011 SHALL have port par_req, output, 1: weight/bias fetch request for channel par_addr.
REQ-012 SHALL have port par_addr, output, CH_W: output channel index being fetched.
REQ-013 SHALL have port par_ack, input, 1: parameter memory presents weight and bias this cycle.
REQ-014 SHALL have port conv_load, output, 1: one-cycle pulse that latches weight and bias into the Conv2d input registers.
REQ-015 SHALL have port res_valid, output, 1: the Conv2d result for res_ch is stable and offered to the writer.
REQ-016 SHALL have port res_ready, input, 1: the writer accepts the result.
REQ-017 SHALL have port res_ch, output, CH_W: channel index of the offered result.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, SETTLE, EMIT, FIN.
REQ-019 SHALL, in IDLE with start=1 and num_ch>0, latch num_ch, clear ch to 0, and enter FETCH; with num_ch=0, enter FIN.
REQ-020 SHALL, in FETCH, hold par_req=1 and par_addr=ch until par_ack=1; on ack it pulses conv_load in the same cycle, loads settle counter with CONV_LAT-1, and enters SETTLE.
REQ-021 SHALL, in SETTLE, decrement the counter each cycle and enter EMIT on the cycle the counter equals 0; SETTLE lasts exactly CONV_LAT cycles.
REQ-022 SHALL, in EMIT, hold res_valid=1 and res_ch=ch stable until res_ready=1; a transfer occurs on res_valid&&res_ready.
REQ-023 SHALL, on transfer, enter FETCH with ch+1 if ch+1<num_ch latched, otherwise enter FIN.
REQ-024 SHALL, in FIN, pulse done for one cycle and return to IDLE; start in FIN is ignored.
REQ-025 SHALL ignore start while busy; latched num_ch SHALL NOT change mid-layer.
REQ-026 SHALL saturate num_ch values above OUTCH to OUTCH.
REQ-027 SHALL ignore par_ack outside FETCH and res_ready outside EMIT.
REQ-028 SHALL produce conv_load as exactly one pulse per channel, never while res_valid=1.

Reset
REQ-029 SHALL, with global_rst=1 at a clk edge in any state, enter IDLE and force busy=0, done=0, par_req=0, par_addr=0, conv_load=0, res_valid=0, res_ch=0, counters=0; an in-flight layer is abandoned and done is never pulsed for it.

Configuration
REQ-030 SHALL, with CONV_CHANNEL_SCHED_PERF_EN defined, add output perf_cycles (32 bits): cleared on start acceptance, incremented every busy cycle, saturating at 2^32-1, held after done, cleared by reset; without the macro the port and counter SHALL NOT exist.

Structure
REQ-031 SHALL take the state enum, CH_W helper function and perf counter width from shared package conv_sched_pkg.
REQ-032 SHALL place the SETTLE down-counter in sub-module conv_settle_timer (load, value, zero flag).

Verification
REQ-033 SHALL cover: num_ch=3, CONV_LAT=4, par_ack and res_ready tied 1 -> 3 conv_load pulses 6 cycles apart, res_ch 0,1,2, done 1 cycle after the last transfer.
REQ-034 SHALL cover: res_ready held low 10 cycles in EMIT -> res_valid and res_ch stable throughout, no extra conv_load, par_req low.
REQ-035 SHALL cover: par_ack delayed 5 cycles -> par_req high and par_addr constant for 5 cycles, conv_load only on the ack cycle.
REQ-036 SHALL cover: start with num_ch=0 -> busy for 1 cycle, done pulse, no par_req/conv_load/res_valid.
REQ-037 SHALL cover: global_rst during SETTLE of channel 1 -> all outputs 0 next cycle, no done; a new start with num_ch=2 then runs channels 0,1.
REQ-038 SHALL cover: with CONV_CHANNEL_SCHED_PERF_EN, num_ch=2, CONV_LAT=4, zero stall -> perf_cycles=14 after done (busy cycles: 2 x (FETCH 1 + SETTLE 4 + EMIT 1) + FIN 1 + start-accept cycle 1).
